me_lsu: RTL and testbench

- Memory-stage load/store unit. It is the consumer of the EX→ME pipeline register outputs: wb_sel, mem_wr_en, bmask, ld_sel, alu_data (used as the address) and rs2_data (used as store data).
- It runs a req/ack transaction on the data-memory port.
- It drives stall_o, which gates that register's enable and all upstream stage enables.
- It returns aligned, sign- or zero-extended load data toward the ME→WB register.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_ld_align.sv | 25 ++
 rtl/me_lsu.sv | 149 ++++++++++++++
 tb/tb_me_lsu.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and the alignment check for the ME-stage LSU.
package lsu_pkg;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  localparam logic [1:0] WB_LD = 2'b01;

  localparam logic [3:0] BMASK_B = 4'b0001;
  localparam logic [3:0] BMASK_H = 4'b0011;
  localparam logic [3:0] BMASK_W = 4'b1111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_e;

  // Loads size from funct3 (anything not byte/half is treated as a word),
  // stores size from the byte mask.
  function automatic logic misaligned(input logic       is_ld,
                                      input logic [2:0] ld_sel,
                                      input logic [3:0] bmask,
                                      input logic [1:0] off);
    logic half, word;
    if (is_ld) begin
      half = (ld_sel == LD_H) || (ld_sel == LD_HU);
      word = !((ld_sel == LD_B) || (ld_sel == LD_BU) || half);
    end else begin
      half = (bmask == BMASK_H);
      word = (bmask == BMASK_W);
    end
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Lane select plus sign/zero extension of a read word; purely combinational.
module lsu_ld_align import lsu_pkg::*; (
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  ld_sel,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  // Pick the addressed byte/half and extend according to the load type.
  always_comb begin
    b = rdata[8*off +: 8];
    h = rdata[16*off[1] +: 16];
    case (ld_sel)
      LD_B:    data = {{24{b[7]}}, b};
      LD_BU:   data = {24'h0, b};
      LD_H:    data = {{16{h[15]}}, h};
      LD_HU:   data = {16'h0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/me_lsu.sv
// Memory-stage load/store unit: one req/ack transaction per memory op,
// stalls the pipeline while BUSY, returns extended load data in DONE.
module me_lsu import lsu_pkg::*; #(
  parameter int TIMEOUT_CYC = 64,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              insn_vld_M,
  input  logic [1:0]        wb_sel_M,
  input  logic              mem_wr_en_M,
  input  logic [3:0]        bmask_M,
  input  logic [2:0]        ld_sel_M,
  input  logic [31:0]       alu_data_M,
  input  logic [31:0]       rs2_data_M,
  output logic              stall_o,
  output logic [31:0]       ld_data_o,
  output logic              ld_vld_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              misalign_o,
  output logic              timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [2:0]        sel_q;
  logic [1:0]        off_q;
  logic              mis_q, to_q;
  logic [31:0]       ld_data_q;
  logic [31:0]       align_data;
  logic              mem_op, mis, to_hit;

  assign mem_op = insn_vld_M && (mem_wr_en_M || (wb_sel_M == WB_LD));
  assign mis    = misaligned(!mem_wr_en_M, ld_sel_M, bmask_M, alu_data_M[1:0]);
  assign to_hit = !mem_ack_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  lsu_ld_align u_align (
    .rdata  (mem_rdata_i),
    .off    (off_q),
    .ld_sel (sel_q),
    .data   (align_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: misaligned ops skip the bus; ack or timeout closes BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op) state_d = mis ? DONE : BUSY;
      BUSY:    if (mem_ack_i || to_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: bus lines are only driven while BUSY so the port idles at zero.
  always_comb begin
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    ld_vld_o    = 1'b0;
    misalign_o  = 1'b0;
    timeout_o   = 1'b0;
    case (state_q)
      IDLE: stall_o = mem_op && !rst;
      BUSY: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_be_o    = be_q;
        mem_wdata_o = wdata_q;
      end
      DONE: begin
        ld_vld_o   = !we_q && !mis_q && !to_q;
        misalign_o = mis_q;
        timeout_o  = to_q;
      end
      default: ;
    endcase
  end
  assign ld_data_o = ld_data_q;

  // Request capture, busy counter, fault flags and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      off_q     <= '0;
      mis_q     <= 1'b0;
      to_q      <= 1'b0;
      ld_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (mem_op) begin
          mis_q <= mis;
          to_q  <= 1'b0;
          cnt_q <= '0;
          we_q  <= mem_wr_en_M;
          if (mis) begin
            ld_data_q <= '0;
          end else begin
            addr_q  <= {alu_data_M[ADDR_W-1:2], 2'b00};
            be_q    <= bmask_M << alu_data_M[1:0];
            wdata_q <= rs2_data_M << {alu_data_M[1:0], 3'b000};
            sel_q   <= ld_sel_M;
            off_q   <= alu_data_M[1:0];
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_ack_i) begin
            if (!we_q) ld_data_q <= align_data;
          end else if (to_hit) begin
            to_q      <= 1'b1;
            ld_data_q <= '0;
          end
        end
        DONE:    cnt_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_me_lsu.sv
// Directed bench for me_lsu: loads, stores, ack latency, faults and reset.
module tb_me_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        insn_vld_M;
  logic [1:0]  wb_sel_M;
  logic        mem_wr_en_M;
  logic [3:0]  bmask_M;
  logic [2:0]  ld_sel_M;
  logic [31:0] alu_data_M;
  logic [31:0] rs2_data_M;
  logic        stall_o;
  logic [31:0] ld_data_o;
  logic        ld_vld_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        misalign_o;
  logic        timeout_o;

  me_lsu #(.TIMEOUT_CYC(16), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .insn_vld_M  (insn_vld_M),
    .wb_sel_M    (wb_sel_M),
    .mem_wr_en_M (mem_wr_en_M),
    .bmask_M     (bmask_M),
    .ld_sel_M    (ld_sel_M),
    .alu_data_M  (alu_data_M),
    .rs2_data_M  (rs2_data_M),
    .stall_o     (stall_o),
    .ld_data_o   (ld_data_o),
    .ld_vld_o    (ld_vld_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .misalign_o  (misalign_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Results of the last run_op.
  int          stall_cnt, req_cnt;
  logic        vld_seen, unstable, finished;
  logic        d_vld, d_mis, d_to;
  logic [31:0] d_data, s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wbs, input logic we, input logic [3:0] bm,
                       input logic [2:0] sel, input logic [31:0] a, input logic [31:0] d);
    insn_vld_M  = 1'b1;
    wb_sel_M    = wbs;
    mem_wr_en_M = we;
    bmask_M     = bm;
    ld_sel_M    = sel;
    alu_data_M  = a;
    rs2_data_M  = d;
  endtask

  // Watch one op from its IDLE cycle to DONE; ack in BUSY cycle ack_at (-1: never).
  task automatic run_op(input int ack_at);
    stall_cnt = 0; req_cnt = 0; vld_seen = 1'b0; unstable = 1'b0; finished = 1'b0;
    d_vld = 1'b0; d_mis = 1'b0; d_to = 1'b0; d_data = '0;
    s_addr = '0; s_wdata = '0; s_be = '0; s_we = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      @(negedge clk);
      if (ld_vld_o) vld_seen = 1'b1;
      if (stall_o) stall_cnt++;
      else begin
        finished = 1'b1;
        d_vld = ld_vld_o; d_data = ld_data_o; d_mis = misalign_o; d_to = timeout_o;
      end
      if (mem_req_o) begin
        if (req_cnt == 0) begin
          s_addr = mem_addr_o; s_wdata = mem_wdata_o; s_be = mem_be_o; s_we = mem_we_o;
        end else if (mem_addr_o !== s_addr || mem_wdata_o !== s_wdata ||
                     mem_be_o !== s_be || mem_we_o !== s_we) begin
          unstable = 1'b1;
        end
        mem_ack_i = (req_cnt == ack_at);
        req_cnt++;
      end else begin
        mem_ack_i = 1'b0;
      end
    end
    chk("op_completes", 32'(finished), 1);
    @(posedge clk); #1;
    insn_vld_M = 1'b0;
    mem_ack_i  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; insn_vld_M = 1'b0; wb_sel_M = '0; mem_wr_en_M = 1'b0; bmask_M = '0;
    ld_sel_M = '0; alu_data_M = '0; rs2_data_M = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {mem_req_o, stall_o, ld_vld_o, misalign_o, timeout_o, mem_we_o, mem_be_o}, 0);
    chk("rst_ld_data", ld_data_o, 0);
    @(posedge clk); #1; rst = 1'b0;

    // LB at 0x1003, ack in first BUSY cycle.
    mem_rdata_i = 32'h80FF1234;
    drive(WB_LD, 1'b0, BMASK_B, LD_B, 32'h0000_1003, 32'h0);
    run_op(0);
    chk("lb_be", 32'(s_be), 32'h8);
    chk("lb_addr", s_addr, 32'h1000);
    chk("lb_stall_cycles", stall_cnt, 2);
    chk("lb_req_cycles", req_cnt, 1);
    chk("lb_vld", 32'(d_vld), 1);
    chk("lb_data", d_data, 32'hFFFFFF80);
    @(negedge clk);
    chk("lb_vld_pulse", 32'(ld_vld_o), 0);
    chk("lb_data_held", ld_data_o, 32'hFFFFFF80);
    @(posedge clk); #1;

    // LHU / LH at 0x1002.
    drive(WB_LD, 1'b0, BMASK_H, LD_HU, 32'h0000_1002, 32'h0);
    run_op(0);
    chk("lhu_be", 32'(s_be), 32'hC);
    chk("lhu_data", d_data, 32'h000080FF);
    drive(WB_LD, 1'b0, BMASK_H, LD_H, 32'h0000_1002, 32'h0);
    run_op(0);
    chk("lh_data", d_data, 32'hFFFF80FF);
    drive(WB_LD, 1'b0, BMASK_H, LD_H, 32'h0000_1000, 32'h0);
    run_op(0);
    chk("lh_lo_data", d_data, 32'h00001234);
    drive(WB_LD, 1'b0, BMASK_B, LD_BU, 32'h0000_1002, 32'h0);
    run_op(0);
    chk("lbu_data", d_data, 32'h000000FF);

    // SB at 0x1001.
    drive(2'b00, 1'b1, BMASK_B, LD_B, 32'h0000_1001, 32'h000000AB);
    run_op(0);
    chk("sb_we", 32'(s_we), 1);
    chk("sb_be", 32'(s_be), 32'h2);
    chk("sb_wdata", s_wdata, 32'h0000AB00);
    chk("sb_addr", s_addr, 32'h1000);
    chk("sb_no_vld", 32'(vld_seen), 0);

    // SW at 0x1004.
    drive(2'b00, 1'b1, BMASK_W, LD_W, 32'h0000_1004, 32'h12345678);
    run_op(1);
    chk("sw_be", 32'(s_be), 32'hF);
    chk("sw_wdata", s_wdata, 32'h12345678);
    chk("sw_addr", s_addr, 32'h1004);

    // LW at 0x2000, ack 3 cycles after req.
    mem_rdata_i = 32'hDEADBEEF;
    drive(WB_LD, 1'b0, BMASK_W, LD_W, 32'h0000_2000, 32'h0);
    run_op(3);
    chk("lw_req_cycles", req_cnt, 4);
    chk("lw_stall_cycles", stall_cnt, 5);
    chk("lw_stable", 32'(unstable), 0);
    chk("lw_addr", s_addr, 32'h2000);
    chk("lw_data", d_data, 32'hDEADBEEF);
    chk("lw_vld", 32'(d_vld), 1);

    // Misaligned LW and SH.
    drive(WB_LD, 1'b0, BMASK_W, LD_W, 32'h0000_1002, 32'h0);
    run_op(0);
    chk("lw_mis_req", req_cnt, 0);
    chk("lw_mis_flag", 32'(d_mis), 1);
    chk("lw_mis_data", d_data, 0);
    chk("lw_mis_vld", 32'(d_vld), 0);
    drive(2'b00, 1'b1, BMASK_H, LD_H, 32'h0000_1001, 32'h0000BEEF);
    run_op(0);
    chk("sh_mis_req", req_cnt, 0);
    chk("sh_mis_flag", 32'(d_mis), 1);

    // Timeout: no ack at all.
    drive(WB_LD, 1'b0, BMASK_W, LD_W, 32'h0000_3000, 32'h0);
    run_op(-1);
    chk("to_req_cycles", req_cnt, 16);
    chk("to_flag", 32'(d_to), 1);
    chk("to_data", d_data, 0);
    chk("to_vld", 32'(d_vld), 0);
    @(negedge clk);
    chk("to_pulse", {30'h0, timeout_o, stall_o}, 0);
    @(posedge clk); #1;

    // Reserved ld_sel behaves as LW.
    mem_rdata_i = 32'hCAFE0042;
    drive(WB_LD, 1'b0, BMASK_W, 3'b111, 32'h0000_1004, 32'h0);
    run_op(0);
    chk("rsv_data", d_data, 32'hCAFE0042);

    // Reset in the second BUSY cycle; a late ack must be ignored.
    drive(WB_LD, 1'b0, BMASK_W, LD_W, 32'h0000_4000, 32'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rstb_req_before", 32'(mem_req_o), 1);
    rst = 1'b1; insn_vld_M = 1'b0;
    @(negedge clk);
    chk("rstb_outputs", {mem_req_o, stall_o, ld_vld_o, misalign_o, timeout_o, mem_we_o, mem_be_o}, 0);
    chk("rstb_ld_data", ld_data_o, 0);
    chk("rstb_addr", mem_addr_o, 0);
    rst = 1'b0; mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    chk("late_ack_out", {29'h0, mem_req_o, stall_o, ld_vld_o}, 0);
    @(negedge clk);
    chk("late_ack_vld", 32'(ld_vld_o), 0);
    chk("late_ack_data", ld_data_o, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
